// File: rtl/md_unit_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: operation codes, sequencer
// state encodings and a helper that classifies multi-cycle operations.
package md_unit_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_RUN = 2'd1;
  localparam logic [1:0] ST_DIV_RUN = 2'd2;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_ctrl_arith.sv
// Combinational 32x32 signed/unsigned multiply and divide. Division works on
// magnitudes so signed results truncate toward zero without overflow traps.
module md_arith
  import md_unit_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic        is_signed;
  logic        is_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    is_div    = (op == MD_DIV) || (op == MD_DIVU);

    a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = a_ext * b_ext;

    neg_a  = is_signed & a[31];
    neg_b  = is_signed & b[31];
    mag_a  = neg_a ? (~a + 32'd1) : a;
    mag_b  = neg_b ? (~b + 32'd1) : b;
    // A zero divisor is replaced so the divider never sees it; the flag suppresses commit.
    safe_b = (b == 32'd0) ? 32'd1 : mag_b;
    uq     = mag_a / safe_b;
    ur     = mag_a % safe_b;
    quot   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem    = neg_a ? (~ur + 32'd1) : ur;

    div_zero = is_div & (b == 32'd0);

    res_hi = 32'd0;
    res_lo = 32'd0;
    if (is_div) begin
      res_hi = rem;
      res_lo = quot;
    end else if ((op == MD_MULT) || (op == MD_MULTU)) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer owning HI/LO: holds busy for a fixed latency,
// commits the pending result at the end and raises the D-stage HI/LO stall.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic        p_dz_q, p_dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] ar_hi;
  logic [31:0] ar_lo;
  logic        ar_dz;

  md_arith u_arith (
    .op       (md_op),
    .a        (rs_val),
    .b        (rt_val),
    .res_hi   (ar_hi),
    .res_lo   (ar_lo),
    .div_zero (ar_dz)
  );

  // Handshake: start is accepted only in a cycle where busy=0; a start seen
  // while busy=1 is dropped (the D-stage stall normally prevents it).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_dz_d  = p_dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              p_hi_d  = ar_hi;
              p_lo_d  = ar_lo;
              p_dz_d  = 1'b0;
              cnt_d   = MULT_LOAD;
              state_d = ST_MUL_RUN;
            end
            MD_DIV, MD_DIVU: begin
              p_hi_d  = ar_hi;
              p_lo_d  = ar_lo;
              p_dz_d  = ar_dz;
              cnt_d   = DIV_LOAD;
              state_d = ST_DIV_RUN;
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (!p_dz_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      p_dz_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_dz_q  <= p_dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign md_stall  = d_is_md & (busy | (start & md_is_long(md_op)));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule
